// File: rtl/result_avg_max.sv
// Batch averager/max-finder between two dav_/rfd handshakes: collects 2^LOG2N
// unsigned 16-bit results and offers floor(sum/N) and the maximum downstream.
module result_avg_max #(
  parameter int LOG2N = 2
) (
  input  logic        clock,
  input  logic        reset_,
  input  logic        dav_in_,
  output logic        rfd_in,
  input  logic [15:0] data_in,
  output logic        dav_out_,
  input  logic        rfd_out,
  output logic [15:0] avg,
  output logic [15:0] max
);

  localparam int N     = 1 << LOG2N;
  localparam int ACC_W = 16 + LOG2N;
  localparam int CNT_W = LOG2N + 1;

  typedef enum logic [1:0] {
    IDLE,
    WREL,
    OFFER,
    WRDY
  } state_t;

  state_t             state, state_nxt;
  logic [ACC_W-1:0]   acc, acc_nxt;
  logic [15:0]        run_max, run_max_nxt;
  logic [CNT_W-1:0]   count, count_nxt;
  logic               rfd_in_nxt, dav_out_nxt;
  logic [15:0]        avg_nxt, max_nxt;

  // Every output is a plain register; the comb block only computes next values.
  always_ff @(posedge clock) begin
    if (reset_) begin
      state    <= IDLE;
      acc      <= '0;
      run_max  <= '0;
      count    <= '0;
      rfd_in   <= 1'b1;
      dav_out_ <= 1'b1;
      avg      <= '0;
      max      <= '0;
    end else begin
      state    <= state_nxt;
      acc      <= acc_nxt;
      run_max  <= run_max_nxt;
      count    <= count_nxt;
      rfd_in   <= rfd_in_nxt;
      dav_out_ <= dav_out_nxt;
      avg      <= avg_nxt;
      max      <= max_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    acc_nxt     = acc;
    run_max_nxt = run_max;
    count_nxt   = count;
    rfd_in_nxt  = rfd_in;
    dav_out_nxt = dav_out_;
    avg_nxt     = avg;
    max_nxt     = max;

    case (state)
      IDLE: begin
        if (!dav_in_) begin
          acc_nxt     = acc + ACC_W'(data_in);
          run_max_nxt = (data_in > run_max) ? data_in : run_max;
          count_nxt   = count + CNT_W'(1);
          rfd_in_nxt  = 1'b0;
          state_nxt   = WREL;
        end
      end

      // A sample is only finished once the producer releases dav_in_.
      WREL: begin
        if (dav_in_) begin
          if (count == CNT_W'(N)) begin
            avg_nxt     = acc[LOG2N +: 16];
            max_nxt     = run_max;
            dav_out_nxt = 1'b0;
            state_nxt   = OFFER;
          end else begin
            rfd_in_nxt = 1'b1;
            state_nxt  = IDLE;
          end
        end
      end

      OFFER: begin
        if (!rfd_out) begin
          dav_out_nxt = 1'b1;
          state_nxt   = WRDY;
        end
      end

      WRDY: begin
        if (rfd_out) begin
          acc_nxt     = '0;
          run_max_nxt = '0;
          count_nxt   = '0;
          rfd_in_nxt  = 1'b1;
          state_nxt   = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_result_avg_max.sv
// Directed self-checking bench for result_avg_max with LOG2N=2 (batches of 4).
module tb_result_avg_max;

  localparam int LOG2N = 2;

  logic        clock = 1'b0;
  logic        reset_;
  logic        dav_in_;
  logic        rfd_in;
  logic [15:0] data_in;
  logic        dav_out_;
  logic        rfd_out;
  logic [15:0] avg;
  logic [15:0] max;

  int pass_count  = 0;
  int check_count = 0;

  always #5 clock = ~clock;

  result_avg_max #(.LOG2N(LOG2N)) dut (
    .clock    (clock),
    .reset_   (reset_),
    .dav_in_  (dav_in_),
    .rfd_in   (rfd_in),
    .data_in  (data_in),
    .dav_out_ (dav_out_),
    .rfd_out  (rfd_out),
    .avg      (avg),
    .max      (max)
  );

  task automatic check_output(input string tag, input logic [15:0] observed,
                              input logic [15:0] expected);
    check_count++;
    assert (observed === expected) pass_count++;
    else $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
  endtask

  // Bounded wait; an expired bound shows up as a failed rfd_in comparison.
  task automatic wait_rfd_in(input logic val, input string tag);
    int n = 0;
    while (rfd_in !== val && n < 100) begin
      @(negedge clock);
      n++;
    end
    check_output(tag, 16'(rfd_in), 16'(val));
  endtask

  task automatic send_sample(input logic [15:0] value, input int extra_hold);
    wait_rfd_in(1'b1, "rfd_in ready");
    data_in = value;
    dav_in_ = 1'b0;
    @(negedge clock);
    repeat (extra_hold) @(negedge clock);
    check_output("rfd_in captured", 16'(rfd_in), 16'd0);
    dav_in_ = 1'b1;
    data_in = 16'hDEAD;
  endtask

  // Called right after the last sample's dav_in_ rise; expects dav_out_ one clock later.
  task automatic receive_batch(input logic [15:0] exp_avg, input logic [15:0] exp_max,
                               input int stall);
    @(negedge clock);
    check_output("dav_out_ latency", 16'(dav_out_), 16'd0);
    check_output("avg", avg, exp_avg);
    check_output("max", max, exp_max);
    check_output("rfd_in offer", 16'(rfd_in), 16'd0);
    if (stall > 0) begin
      data_in = 16'd999;
      dav_in_ = 1'b0;
      repeat (stall) @(negedge clock);
      check_output("stall dav_out_", 16'(dav_out_), 16'd0);
      check_output("stall avg", avg, exp_avg);
      check_output("stall max", max, exp_max);
      check_output("stall rfd_in", 16'(rfd_in), 16'd0);
      dav_in_ = 1'b1;
      data_in = 16'hDEAD;
    end
    rfd_out = 1'b0;
    @(negedge clock);
    check_output("dav_out_ release", 16'(dav_out_), 16'd1);
    check_output("rfd_in wrdy", 16'(rfd_in), 16'd0);
    rfd_out = 1'b1;
    @(negedge clock);
    check_output("rfd_in reopen", 16'(rfd_in), 16'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_  = 1'b1;
    dav_in_ = 1'b1;
    rfd_out = 1'b1;
    data_in = 16'd0;
    repeat (2) @(negedge clock);
    check_output("reset rfd_in", 16'(rfd_in), 16'd1);
    check_output("reset dav_out_", 16'(dav_out_), 16'd1);
    check_output("reset avg", avg, 16'd0);
    check_output("reset max", max, 16'd0);
    reset_ = 1'b0;
    @(negedge clock);

    $display("[TB] batch 100,200,400,300");
    send_sample(16'd100, 0);
    send_sample(16'd200, 0);
    send_sample(16'd400, 0);
    check_output("no early offer", 16'(dav_out_), 16'd1);
    send_sample(16'd300, 0);
    receive_batch(16'd250, 16'd400, 0);

    $display("[TB] batch 0xFFFF x4");
    for (int i = 0; i < 4; i++) send_sample(16'hFFFF, 0);
    receive_batch(16'hFFFF, 16'hFFFF, 0);

    $display("[TB] long dav_in_ pulse then 4,4,4 with downstream stall");
    send_sample(16'd8, 9);
    send_sample(16'd4, 0);
    send_sample(16'd4, 0);
    check_output("held counts once", 16'(dav_out_), 16'd1);
    send_sample(16'd4, 0);
    receive_batch(16'd5, 16'd8, 20);

    $display("[TB] batch 1,2,2,2");
    send_sample(16'd1, 0);
    send_sample(16'd2, 0);
    send_sample(16'd2, 0);
    send_sample(16'd2, 0);
    receive_batch(16'd1, 16'd2, 0);

    $display("[TB] reset mid-batch then 10,20,30,40");
    send_sample(16'd500, 0);
    send_sample(16'd600, 0);
    reset_ = 1'b1;
    @(negedge clock);
    reset_ = 1'b0;
    check_output("abort rfd_in", 16'(rfd_in), 16'd1);
    check_output("abort dav_out_", 16'(dav_out_), 16'd1);
    check_output("abort avg", avg, 16'd0);
    check_output("abort max", max, 16'd0);
    send_sample(16'd10, 0);
    send_sample(16'd20, 0);
    send_sample(16'd30, 0);
    send_sample(16'd40, 0);
    receive_batch(16'd25, 16'd40, 0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
